// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS = 10;

  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle of the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8
);
  logic [7:0]             tx_data;
  logic                   tx_en;
  logic                   tx_full;
  logic                   tx_busy;
  logic                   tx_overflow;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   uart_tx;

  modport master (
    output tx_data,
    output tx_en,
    input  tx_full,
    input  tx_busy,
    input  tx_overflow,
    input  fifo_count,
    input  uart_tx
  );

  modport slave (
    input  tx_data,
    input  tx_en,
    output tx_full,
    output tx_busy,
    output tx_overflow,
    output fifo_count,
    output uart_tx
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word fall-through read data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  // Fullness is judged on the pre-edge count, even alongside a pop.
  assign full  = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  assign dout  = r_mem[r_head];
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + 1'b1;
      if (w_rd) r_head <= r_head + 1'b1;
      if (w_wr && !w_rd)
        r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_tail] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter, LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input logic         sys_clk,
  input logic         rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  tx_state_t             r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [2:0]            r_bit, w_bit_nx;
  logic [7:0]            r_shift, w_shift_nx;
  logic                  r_tx;
  logic                  r_ovf;
  logic                  w_pop;
  logic                  w_wrap;
  logic [7:0]            w_dout;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (bus.tx_en),
    .pop   (w_pop),
    .din   (bus.tx_data),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_wrap = r_cnt == LAST;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= (r_state == START) ? 1'b0 :
                 (r_state == DATA)  ? r_shift[0] : 1'b1;
      r_ovf   <= r_ovf | (bus.tx_en & w_full);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    if (r_state != IDLE)
      w_cnt_nx = w_wrap ? '0 : r_cnt + 1'b1;
    unique case (1'b1)
      (r_state == IDLE): begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_dout;
          w_cnt_nx   = '0;
          w_state_nx = START;
        end
      end
      (r_state == START): begin
        if (w_wrap) begin
          w_bit_nx   = '0;
          w_state_nx = DATA;
        end
      end
      (r_state == DATA): begin
        if (w_wrap) begin
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nx = STOP;
        end
      end
      (r_state == STOP): begin
        // Chain straight into the next start bit when more is queued.
        if (w_wrap) begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_dout;
            w_state_nx = START;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.tx_full     = w_full;
  assign bus.tx_busy     = (r_state != IDLE) || !w_empty;
  assign bus.tx_overflow = r_ovf;
  assign bus.fifo_count  = w_count;
  assign bus.uart_tx     = r_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for the buffered UART transmitter.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 27000000;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;
  localparam int CNTW     = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  int         m_left = 0;
  bit         m_ovf  = 0;
  int         cyc    = 0;
  bit         chk_en = 0;
  int         n_vec  = 0;
  int         n_err  = 0;

  // Reference: a frame holds the transmitter for FRAME cycles; a byte
  // leaves the queue when the transmitter is free or finishing a frame.
  always @(posedge sys_clk) begin
    int   pre;
    bit   do_pop;
    exp_t e;
    cyc++;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_left = 0;
      m_ovf  = 0;
      chk_en = 1;
    end else begin
      pre    = m_q.size();
      do_pop = (m_left <= 1) && (pre != 0);
      if (m_left > 0) m_left--;
      if (bus.tx_en === 1'b1) begin
        if (pre < DEPTH) m_q.push_back(bus.tx_data);
        else m_ovf = 1;
      end
      if (do_pop) begin
        e.b = m_q.pop_front();
        e.t = cyc + 1;
        exp_q.push_back(e);
        m_left = FRAME;
      end
    end
  end

  always @(negedge sys_clk) begin
    int  sz;
    bit  busy;
    if (chk_en) begin
      sz   = m_q.size();
      busy = (m_left > 0) || (sz > 0);
      n_vec++;
      if (bus.fifo_count !== CNTW'(sz) ||
          bus.tx_full !== (sz == DEPTH) ||
          bus.tx_busy !== busy ||
          bus.tx_overflow !== m_ovf) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL status cyc=%0d got cnt=%0d full=%b busy=%b ovf=%b want cnt=%0d full=%b busy=%b ovf=%b",
                   cyc, bus.fifo_count, bus.tx_full, bus.tx_busy,
                   bus.tx_overflow, sz, sz == DEPTH, busy, m_ovf);
      end
    end
  end

  bit         mon_act = 0;
  int         mon_f   = 0;
  int         mon_k   = 0;
  logic [9:0] mon_bits;

  // Line decoder: sample each bit at its centre after a falling edge.
  always @(negedge sys_clk) begin
    logic [7:0] got;
    if (rst || !chk_en) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (bus.uart_tx !== 1'b1) begin
        mon_act = 1;
        mon_f   = cyc;
        mon_k   = 0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL line_start cyc=%0d got unexpected start want idle", cyc);
        end else if (exp_q[0].t != cyc) begin
          n_err++;
          $display("FAIL start_time got %0d want %0d", cyc, exp_q[0].t);
        end
      end
    end else if (cyc == mon_f + mon_k * DIV + DIV / 2) begin
      mon_bits[mon_k] = bus.uart_tx;
      mon_k++;
      if (mon_k == 10) begin
        mon_act = 0;
        got     = mon_bits[8:1];
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame got %02h want none", got);
        end else begin
          if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1 ||
              got !== exp_q[0].b) begin
            n_err++;
            $display("FAIL frame got bits=%b want byte %02h framed",
                     mon_bits, exp_q[0].b);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.tx_en   = 1'b1;
    bus.tx_data = b;
    tick(1);
    bus.tx_en   = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_left == 0 && m_q.size() == 0 && !mon_act) break;
      tick(1);
    end
    n_vec++;
    if (i == budget || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s got %0d cycles/%0d left want idle",
               nm, i, exp_q.size());
    end
    tick(5);
  endtask

  initial begin
    int pk;
    int i;
    bus.tx_en   = 1'b0;
    bus.tx_data = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_uart_tx", 32'(bus.uart_tx), 1);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_busy", 32'(bus.tx_busy), 0);
    chk("rst_full", 32'(bus.tx_full), 0);
    tick(1000);
    chk("idle_uart_tx", 32'(bus.uart_tx), 1);

    wr(8'h55);
    drain("single", FRAME + 50);

    pk = 0;
    wr(8'h41);
    if (int'(bus.fifo_count) > pk) pk = int'(bus.fifo_count);
    wr(8'h42);
    if (int'(bus.fifo_count) > pk) pk = int'(bus.fifo_count);
    wr(8'h43);
    if (int'(bus.fifo_count) > pk) pk = int'(bus.fifo_count);
    chk("b2b_peak", 32'(pk), 2);
    drain("b2b", 3 * FRAME + 50);

    for (int b = 0; b < 10; b++) wr(8'(b));
    chk("ovf_full", 32'(bus.tx_full), 1);
    chk("ovf_flag", 32'(bus.tx_overflow), 1);
    drain("ovf", 10 * FRAME);
    chk("ovf_sticky", 32'(bus.tx_overflow), 1);

    wr(8'hA5);
    tick(2 + 4 * DIV + DIV / 2);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_tx", 32'(bus.uart_tx), 1);
    chk("mid_rst_cnt", 32'(bus.fifo_count), 0);
    chk("mid_rst_ovf", 32'(bus.tx_overflow), 0);
    rst = 1'b0;
    tick(3);
    wr(8'h3C);
    drain("after_rst", FRAME + 50);

    for (int b = 0; b < DEPTH + 1; b++) wr(8'($urandom));
    chk("fill_full", 32'(bus.tx_full), 1);
    for (i = 0; i < 2 * FRAME; i++) begin
      if (m_left == 1) break;
      tick(1);
    end
    chk("stop_wait", 32'(i < 2 * FRAME), 1);
    chk("pre_ovf", 32'(bus.tx_overflow), 0);
    wr(8'hEE);
    chk("pop_ovf", 32'(bus.tx_overflow), 1);
    chk("pop_cnt", 32'(bus.fifo_count), DEPTH - 1);
    drain("full_pop", 10 * FRAME);

    for (int r = 0; r < 6; r++) begin
      tick($urandom_range(0, 3 * DIV));
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        wr(8'($urandom));
    end
    drain("rand", 20 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
